// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC arbitration, IF/ID control, flush bubbles and HALT/step debug.
// Optional fetch counter enabled by defining PC_SEQUENCER_FETCH_COUNT_EN.
module pc_sequencer #(
    parameter int                 ADDR_W       = 10,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int                 FLUSH_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic              stall_req,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              step,
    output logic              PC_write,
    output logic [ADDR_W-1:0] PC_new,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {RUN, FLUSH, HALT, STEP} state_e;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              redirect;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] pc_seq;

    // Branch is older than the jump in ID, so it wins and the jump is dropped.
    assign redirect = branch_taken | jump_req;
    assign redir_pc = branch_taken ? branch_target : jump_target;
    assign pc_seq   = pc_current + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PC_write    = 1'b0;
        PC_new      = pc_seq;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b0;
        halted      = 1'b0;
        if (!reset_n) begin
            PC_write    = 1'b1;
            PC_new      = RESET_PC;
            IF_ID_flush = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else begin
            case (state_q)
                RUN, STEP: begin
                    if (redirect) begin
                        PC_write    = 1'b1;
                        PC_new      = redir_pc;
                        IF_ID_write = 1'b1;
                        IF_ID_flush = 1'b1;
                        cnt_d       = FLUSH_LOAD;
                        state_d     = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
                    end else if (halt_req) begin
                        state_d = HALT;
                    end else if (!stall_req) begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                    end
                    // A single step always lands back in HALT with no pending bubbles.
                    if (state_q == STEP) begin
                        state_d = HALT;
                        cnt_d   = '0;
                    end
                end
                FLUSH: begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    IF_ID_flush = 1'b1;
                    if (redirect) begin
                        PC_new  = redir_pc;
                        cnt_d   = FLUSH_LOAD;
                        state_d = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
                    end else begin
                        cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                        state_d = (cnt_q <= 3'd1) ? RUN : FLUSH;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                    if (resume)    state_d = RUN;
                    else if (step) state_d = STEP;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_SEQUENCER_FETCH_COUNT_EN
    logic [15:0] fcnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n)
            fcnt_q <= '0;
        else if (PC_write && fcnt_q != 16'hFFFF)
            fcnt_q <= fcnt_q + 16'd1;
    end

    assign fetch_count = fcnt_q;
`else
    assign fetch_count = '0;
`endif

endmodule
